// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
package regfile_pkg;

  localparam int AddressBitwidth = 5;
  localparam int DataBitwidth    = 32;

  typedef logic [AddressBitwidth-1:0] reg_addr_t;
  typedef logic [DataBitwidth-1:0]    reg_data_t;

  // Which requester holds the round-robin priority for the next tie.
  typedef enum logic {GRANT_ALU, GRANT_LD} grant_e;

endpackage

// File: rtl/register_scoreboard.sv
// One pending bit per register for loads still in flight to memory.
// Register 0 is hardwired and never becomes pending.
module register_scoreboard #(
  parameter int AddressBitwidth = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          set_en,
  input  logic [AddressBitwidth-1:0]    set_addr,
  input  logic                          clr_en,
  input  logic [AddressBitwidth-1:0]    clr_addr,
  input  logic [AddressBitwidth-1:0]    lookup_a,
  input  logic [AddressBitwidth-1:0]    lookup_b,
  output logic                          busy_a,
  output logic                          busy_b,
  output logic [2**AddressBitwidth-1:0] pending
);

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en && (set_addr != '0)) pending[set_addr] <= 1'b1;
    end
  end

  assign busy_a = pending[lookup_a];
  assign busy_b = pending[lookup_b];

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the register-file write port between the ALU and the load unit,
// tracks outstanding loads and flags read-after-write hazards for decode.
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int AddressBitwidth = 5,
  parameter int DataBitwidth    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AddressBitwidth-1:0] alu_rd,
  input  logic [DataBitwidth-1:0]    alu_data,
  input  logic                       ld_issue,
  input  logic [AddressBitwidth-1:0] ld_issue_rd,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [AddressBitwidth-1:0] ld_rd,
  input  logic [DataBitwidth-1:0]    ld_data,
  input  logic [AddressBitwidth-1:0] rs1,
  input  logic [AddressBitwidth-1:0] rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [AddressBitwidth-1:0] rf_rd,
  output logic                       rf_write_enable,
  output logic [DataBitwidth-1:0]    rf_data
);

  grant_e                       rr_ptr;
  logic [2**AddressBitwidth-1:0] pending;
  logic                         rs1_pending;
  logic                         rs2_pending;
  logic                         alu_elig;
  logic                         alu_fire;
  logic                         ld_fire;
  logic                         both_req;

  logic                         alu_stall_q;
  logic [AddressBitwidth-1:0]   alu_rd_q;
  logic [DataBitwidth-1:0]      alu_data_q;
  logic                         ld_stall_q;
  logic [AddressBitwidth-1:0]   ld_rd_q;
  logic [DataBitwidth-1:0]      ld_data_q;

  register_scoreboard #(.AddressBitwidth(AddressBitwidth)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (ld_issue),
    .set_addr (ld_issue_rd),
    .clr_en   (ld_fire),
    .clr_addr (ld_rd),
    .lookup_a (rs1),
    .lookup_b (rs2),
    .busy_a   (rs1_pending),
    .busy_b   (rs2_pending),
    .pending  (pending)
  );

  // An ALU write may not overtake a load still outstanding to the same register.
  assign alu_elig = (alu_rd == '0) | ~pending[alu_rd];

  // Ready depends only on the other side's valid; reset holds both off.
  assign alu_ready = rst_n & alu_elig & ~(ld_valid & (rr_ptr == GRANT_LD));
  assign ld_ready  = rst_n & ~(alu_valid & alu_elig & (rr_ptr == GRANT_ALU));
  assign alu_fire  = alu_valid & alu_ready;
  assign ld_fire   = ld_valid & ld_ready;
  assign both_req  = alu_valid & alu_elig & ld_valid;

  // Round-robin pointer flips only when both requesters competed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= GRANT_ALU;
    end else if (both_req) begin
      rr_ptr <= (rr_ptr == GRANT_ALU) ? GRANT_LD : GRANT_ALU;
    end
  end

  // Output stage: the accepted write appears on the register-file port one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_enable <= 1'b0;
      rf_rd           <= '0;
      rf_data         <= '0;
    end else if (alu_fire) begin
      rf_write_enable <= (alu_rd != '0);
      rf_rd           <= alu_rd;
      rf_data         <= alu_data;
    end else if (ld_fire) begin
      rf_write_enable <= (ld_rd != '0);
      rf_rd           <= ld_rd;
      rf_data         <= ld_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  // A register is stale while its load is outstanding or its write has not yet committed.
  assign rs1_busy = (rs1 != '0) & (rs1_pending | (rf_write_enable & (rf_rd == rs1)));
  assign rs2_busy = (rs2 != '0) & (rs2_pending | (rf_write_enable & (rf_rd == rs2)));

  // Remember stalled offers so the following cycle can confirm they were held steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_stall_q <= 1'b0;
      alu_rd_q    <= '0;
      alu_data_q  <= '0;
      ld_stall_q  <= 1'b0;
      ld_rd_q     <= '0;
      ld_data_q   <= '0;
    end else begin
      alu_stall_q <= alu_valid & ~alu_ready;
      alu_rd_q    <= alu_rd;
      alu_data_q  <= alu_data;
      ld_stall_q  <= ld_valid & ~ld_ready;
      ld_rd_q     <= ld_rd;
      ld_data_q   <= ld_data;
    end
  end

  // Protocol checks on the requesters; these have no recovery path in hardware.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(ld_issue && (ld_issue_rd != '0) && pending[ld_issue_rd]
                && !(ld_fire && (ld_rd == ld_issue_rd))));
      assert (!ld_valid || (ld_rd == '0) || pending[ld_rd]);
      assert (!alu_stall_q || (alu_valid && (alu_rd == alu_rd_q) && (alu_data == alu_data_q)));
      assert (!ld_stall_q || (ld_valid && (ld_rd == ld_rd_q) && (ld_data == ld_data_q)));
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for the writeback arbiter, with a simple register-file model
// that commits whatever the DUT drives on its write port.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rf_rd;
  logic        rf_write_enable;
  logic [31:0] rf_data;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

  regfile_writeback_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_issue        (ld_issue),
    .ld_issue_rd     (ld_issue_rd),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_rd           (ld_rd),
    .ld_data         (ld_data),
    .rs1             (rs1),
    .rs2             (rs2),
    .rs1_busy        (rs1_busy),
    .rs2_busy        (rs2_busy),
    .rf_rd           (rf_rd),
    .rf_write_enable (rf_write_enable),
    .rf_data         (rf_data)
  );

  always #5 clk = ~clk;

  // Register file model: commits the write port at the end of each cycle.
  always @(posedge clk) begin
    if (rf_write_enable) regs[rf_rd] <= rf_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    rs1 = '0; rs2 = '0;
    tick(); tick();
    check("reset_we", 32'(rf_write_enable), 32'd0);
    check("reset_rd", 32'(rf_rd), 32'd0);
    check("reset_data", rf_data, 32'd0);
    check("reset_alu_ready", 32'(alu_ready), 32'd0);
    check("reset_ld_ready", 32'(ld_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset arrives in the same cycle as an ALU offer.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    #1 rst_n = 1'b0;
    #1 check("t1_ready_in_reset", 32'(alu_ready), 32'd0);
    tick();
    check("t1_we", 32'(rf_write_enable), 32'd0);
    alu_valid = 1'b0;
    tick();
    check("t1_we_later", 32'(rf_write_enable), 32'd0);
    check("t1_x3", regs[3], 32'h0);
    rst_n = 1'b1;
    tick();

    // Lone ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("t2_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("t2_we", 32'(rf_write_enable), 32'd1);
    check("t2_rd", 32'(rf_rd), 32'd5);
    check("t2_data", rf_data, 32'hDEADBEEF);
    tick();
    check("t2_we_one_cycle", 32'(rf_write_enable), 32'd0);
    check("t2_data_hold", rf_data, 32'hDEADBEEF);
    check("t2_x5", regs[5], 32'hDEADBEEF);

    // Contention: loads to x2 and x4 outstanding, both sides offering.
    ld_issue = 1'b1; ld_issue_rd = 5'd2;
    tick();
    ld_issue_rd = 5'd4;
    tick();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'hB2;
    #1 check("t3_c1_alu_ready", 32'(alu_ready), 32'd1);
    check("t3_c1_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    alu_data = 32'hA2;
    #1 check("t3_c2_ld_ready", 32'(ld_ready), 32'd1);
    check("t3_c2_alu_ready", 32'(alu_ready), 32'd0);
    check("t3_c2_rf_rd", 32'(rf_rd), 32'd1);
    check("t3_c2_rf_data", rf_data, 32'hA1);
    tick();
    ld_rd = 5'd4; ld_data = 32'hB4;
    #1 check("t3_c3_alu_ready", 32'(alu_ready), 32'd1);
    check("t3_c3_ld_ready", 32'(ld_ready), 32'd0);
    check("t3_c3_rf_rd", 32'(rf_rd), 32'd2);
    check("t3_c3_rf_data", rf_data, 32'hB2);
    tick();
    alu_data = 32'hA3;
    #1 check("t3_c4_ld_ready", 32'(ld_ready), 32'd1);
    check("t3_c4_alu_ready", 32'(alu_ready), 32'd0);
    check("t3_c4_rf_data", rf_data, 32'hA2);
    tick();
    ld_valid = 1'b0;
    #1 check("t3_c5_alu_ready", 32'(alu_ready), 32'd1);
    check("t3_c5_rf_rd", 32'(rf_rd), 32'd4);
    check("t3_c5_rf_data", rf_data, 32'hB4);
    tick();
    alu_valid = 1'b0;
    check("t3_c6_rf_data", rf_data, 32'hA3);
    check("t3_x2", regs[2], 32'hB2);

    // Load scoreboard on x7 with a waiting ALU write to the same register.
    ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7;
    tick();
    ld_issue = 1'b0;
    #1 check("t4_rs1_busy", 32'(rs1_busy), 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1 check("t4_waw_block", 32'(alu_ready), 32'd0);
    tick();
    check("t4_waw_block2", 32'(alu_ready), 32'd0);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h700;
    #1 check("t4_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    #1 check("t4_rs1_window", 32'(rs1_busy), 32'd1);
    check("t4_alu_now_ready", 32'(alu_ready), 32'd1);
    check("t4_rf_rd", 32'(rf_rd), 32'd7);
    tick();
    alu_valid = 1'b0;
    check("t4_x7_load", regs[7], 32'h700);
    check("t4_rf_alu", rf_data, 32'h77);
    tick();
    check("t4_rs1_clear", 32'(rs1_busy), 32'd0);
    check("t4_x7_alu", regs[7], 32'h77);

    // Writes to x0 are accepted and discarded.
    ld_issue = 1'b1; ld_issue_rd = 5'd0; rs1 = 5'd0;
    tick();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    #1 check("t5_alu_ready", 32'(alu_ready), 32'd1);
    check("t5_rs1_busy", 32'(rs1_busy), 32'd0);
    tick();
    alu_valid = 1'b0;
    check("t5_we", 32'(rf_write_enable), 32'd0);
    check("t5_rs1_busy2", 32'(rs1_busy), 32'd0);

    // Same-cycle clear and set of x9.
    ld_issue = 1'b1; ld_issue_rd = 5'd9; rs2 = 5'd9;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    #1 check("t6_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_issue = 1'b0; ld_valid = 1'b0;
    tick();
    check("t6_pending_kept", 32'(rs2_busy), 32'd1);
    check("t6_x9", regs[9], 32'h99);
    ld_valid = 1'b1; ld_data = 32'h9A;
    tick();
    ld_valid = 1'b0;
    tick();
    check("t6_pending_cleared", 32'(rs2_busy), 32'd0);
    check("t6_x9_second", regs[9], 32'h9A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
